fetch_stage: RTL and testbench

//  Instruction-fetch stage directly downstream of the PC selection logic.

---
 rtl/fetch_stage.sv | 127 ++++++++++++
 tb/tb_fetch_stage.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: issues request/acknowledge reads to instruction memory,
// loads the IF/ID pipeline register and stalls PC selection while a fetch is busy.
`timescale 1ns/1ps
module fetch_stage #(
  parameter logic [31:0] NOP_INSTR   = 32'h00000000,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pc_in,
  input  logic        flush,
  input  logic        id_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        fetch_stall,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        imem_err
);
  localparam int            CW      = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_MAX  = CW'(ACK_TIMEOUT);
  localparam logic [CW-1:0] TO_LAST = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t        r_state;
  logic [31:0]   r_fetchPc;
  logic [31:0]   r_holdInstr;
  logic [31:0]   r_holdPc;
  logic          r_kill;
  logic [CW-1:0] r_toCnt;

  logic          w_ackLive;
  logic          w_takePc;
  logic          w_deliver;
  logic [31:0]   w_dInstr;
  logic [31:0]   w_dPc;

  // An ack parked in the hold buffer does not advance fetch_pc, so PC selection stays held.
  always_comb begin
    w_ackLive = (r_state == REQ) && imem_ack && !r_kill && !flush;
    w_takePc  = 1'b0;
    w_deliver = 1'b0;
    w_dInstr  = imem_rdata;
    w_dPc     = r_fetchPc;
    case (r_state)
      IDLE: w_takePc = 1'b1;
      REQ: begin
        if (imem_ack) begin
          w_takePc  = !w_ackLive || !id_stall;
          w_deliver = w_ackLive && !id_stall;
        end
      end
      HOLD: begin
        w_takePc  = flush || !id_stall;
        w_deliver = !flush && !id_stall;
        w_dInstr  = r_holdInstr;
        w_dPc     = r_holdPc;
      end
      default: ;
    endcase
  end

  assign imem_req    = (r_state == REQ);
  assign imem_addr   = r_fetchPc;
  assign fetch_stall = !w_takePc || (r_state == IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_fetchPc   <= '0;
      r_holdInstr <= '0;
      r_holdPc    <= '0;
      r_kill      <= 1'b0;
      r_toCnt     <= '0;
      imem_err    <= 1'b0;
      if_id_instr <= NOP_INSTR;
      if_id_pc    <= '0;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
    end else begin
      if (w_takePc)
        r_fetchPc <= pc_in;

      if (w_deliver) begin
        if_id_instr <= w_dInstr;
        if_id_pc    <= w_dPc;
        if_id_pc4   <= w_dPc + 32'd4;
        if_id_valid <= 1'b1;
      end else if (flush || !id_stall) begin
        if_id_instr <= NOP_INSTR;
        if_id_valid <= 1'b0;
      end

      case (r_state)
        IDLE: r_state <= REQ;
        REQ: begin
          if (imem_ack) begin
            r_kill  <= 1'b0;
            r_toCnt <= '0;
            if (w_ackLive && id_stall) begin
              r_holdInstr <= imem_rdata;
              r_holdPc    <= r_fetchPc;
              r_state     <= HOLD;
            end
          end else begin
            if (flush)
              r_kill <= 1'b1;
            if (r_toCnt != TO_MAX)
              r_toCnt <= r_toCnt + 1'b1;
            if (r_toCnt == TO_LAST)
              imem_err <= 1'b1;
          end
        end
        HOLD: begin
          if (w_takePc)
            r_state <= REQ;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed stimulus, a latency-programmable memory responder,
// a queue-based reference model compared every cycle, and hand-computed spot checks.
`timescale 1ns/1ps
module tb_fetch_stage;
  localparam logic [31:0] NOP        = 32'h00000000;
  localparam int          ACK_TO     = 16;

  logic        clk;
  logic        reset_n;
  logic [31:0] pc_in;
  logic        flush;
  logic        id_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        fetch_stall;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        imem_err;

  int compared = 0;
  int mismatched = 0;
  int ackDelay = 0;
  int ackAge = 0;

  fetch_stage #(.NOP_INSTR(NOP), .ACK_TIMEOUT(ACK_TO)) dut (
    .clk(clk), .reset_n(reset_n), .pc_in(pc_in), .flush(flush), .id_stall(id_stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .fetch_stall(fetch_stall), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
    .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid), .imem_err(imem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h00000100) return 32'h8C220004;
    return a ^ 32'h0BAD0013;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: acks once a request has been waiting ackDelay cycles.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      if (imem_req && ackAge >= ackDelay) begin
        imem_ack   = 1'b1;
        imem_rdata = memWord(imem_addr);
        ackAge     = 0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEADBEEF;
        ackAge     = imem_req ? ackAge + 1 : 0;
      end
    end
  end

  // Reference model: fetch pointer, at most one parked word, kill flag, wait count.
  bit          mStarted = 0;
  bit          mKill = 0;
  bit          mErr = 0;
  bit          mValid = 0;
  int          mWait = 0;
  logic [31:0] mPc = 0;
  logic [31:0] mInstr = NOP;
  logic [31:0] mIfPc = 0;
  logic [31:0] mIfPc4 = 0;
  logic [63:0] mHeld[$];
  bit          mDeliver;
  bit          mTake;
  logic [63:0] mWord;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mStarted = 0; mKill = 0; mErr = 0; mValid = 0; mWait = 0;
      mPc = 0; mInstr = NOP; mIfPc = 0; mIfPc4 = 0;
      mHeld.delete();
    end else begin
      mDeliver = 0;
      mTake    = 0;
      mWord    = '0;
      if (!mStarted) begin
        mTake = 1;
      end else if (mHeld.size() == 0) begin
        if (imem_ack) begin
          if (mKill || flush) mTake = 1;
          else if (id_stall) mHeld.push_back({imem_rdata, mPc});
          else begin mDeliver = 1; mWord = {imem_rdata, mPc}; mTake = 1; end
          mKill = 0;
          mWait = 0;
        end else begin
          if (flush) mKill = 1;
          mWait++;
          if (mWait >= ACK_TO) mErr = 1;
        end
      end else if (flush) begin
        mHeld.delete();
        mTake = 1;
      end else if (!id_stall) begin
        mWord = mHeld.pop_front();
        mDeliver = 1;
        mTake = 1;
      end
      if (mDeliver) begin
        mInstr = mWord[63:32];
        mIfPc  = mWord[31:0];
        mIfPc4 = mWord[31:0] + 32'd4;
        mValid = 1;
      end else if (flush || !id_stall) begin
        mInstr = NOP;
        mValid = 0;
      end
      if (mTake) mPc = pc_in;
      mStarted = 1;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (reset_n) begin
      bit expReq;
      bit expStall;
      expReq   = mStarted && (mHeld.size() == 0);
      expStall = !((expReq && imem_ack && (mKill || flush || !id_stall)) ||
                   (mHeld.size() != 0 && (flush || !id_stall)));
      checkOutput("model.req", 32'(imem_req), 32'(expReq));
      if (expReq) checkOutput("model.addr", imem_addr, mPc);
      checkOutput("model.stall", 32'(fetch_stall), 32'(expStall));
      checkOutput("model.instr", if_id_instr, mInstr);
      checkOutput("model.pc", if_id_pc, mIfPc);
      checkOutput("model.pc4", if_id_pc4, mIfPc4);
      checkOutput("model.valid", 32'(if_id_valid), 32'(mValid));
      checkOutput("model.err", 32'(imem_err), 32'(mErr));
    end
  end

  task automatic applyStimulus(input int c);
    @(posedge clk);
    #1;
    case (c)
      1:  pc_in = 32'h4;
      2:  pc_in = 32'h8;
      3:  pc_in = 32'hC;
      4:  begin pc_in = 32'h100; ackDelay = 3; end
      11: pc_in = 32'h200;
      15: begin id_stall = 1; ackDelay = 0; pc_in = 32'h300; end
      18: id_stall = 0;
      19: begin ackDelay = 3; pc_in = 32'h999; end
      20: flush = 1;
      21: flush = 0;
      22: begin pc_in = 32'h40; ackDelay = 0; end
      23: pc_in = 32'h44;
      24: begin flush = 1; pc_in = 32'h80; end
      25: begin flush = 0; pc_in = 32'hFFFFFFFC; end
      26: pc_in = 32'h0;
      27: begin ackDelay = 1000; pc_in = 32'h20; end
      48: ackDelay = 0;
      50: ackDelay = 1000;
      default: ;
    endcase
  endtask

  task automatic directedChecks(input int c);
    case (c)
      1: begin checkOutput("firstReq", 32'(imem_req), 1); checkOutput("firstAddr", imem_addr, 32'h0); end
      2: begin
        checkOutput("s0.pc", if_id_pc, 32'h0); checkOutput("s0.pc4", if_id_pc4, 32'h4);
        checkOutput("s0.valid", 32'(if_id_valid), 1); checkOutput("s0.instr", if_id_instr, 32'h0BAD0013);
      end
      3: begin checkOutput("s1.pc", if_id_pc, 32'h4); checkOutput("s1.pc4", if_id_pc4, 32'h8); end
      4: begin
        checkOutput("s2.pc", if_id_pc, 32'h8); checkOutput("s2.pc4", if_id_pc4, 32'hC);
        checkOutput("s2.valid", 32'(if_id_valid), 1);
      end
      8, 9, 10: begin
        checkOutput("wait.addr", imem_addr, 32'h100); checkOutput("wait.stall", 32'(fetch_stall), 1);
        checkOutput("wait.req", 32'(imem_req), 1);
      end
      12: begin
        checkOutput("wait.instr", if_id_instr, 32'h8C220004); checkOutput("wait.pc", if_id_pc, 32'h100);
        checkOutput("wait.valid", 32'(if_id_valid), 1);
      end
      13: begin checkOutput("once.valid", 32'(if_id_valid), 0); checkOutput("once.instr", if_id_instr, NOP); end
      16: begin
        checkOutput("hold.req", 32'(imem_req), 0); checkOutput("hold.stall", 32'(fetch_stall), 1);
        checkOutput("hold.valid", 32'(if_id_valid), 0); checkOutput("hold.pc", if_id_pc, 32'h100);
      end
      18: checkOutput("release.stall", 32'(fetch_stall), 0);
      19: begin
        checkOutput("release.instr", if_id_instr, 32'h0BAD0213); checkOutput("release.pc", if_id_pc, 32'h200);
        checkOutput("release.valid", 32'(if_id_valid), 1); checkOutput("release.addr", imem_addr, 32'h300);
      end
      21: begin checkOutput("flush.valid", 32'(if_id_valid), 0); checkOutput("flush.instr", if_id_instr, NOP); end
      23: begin checkOutput("killed.valid", 32'(if_id_valid), 0); checkOutput("target.addr", imem_addr, 32'h40); end
      24: begin checkOutput("target.pc", if_id_pc, 32'h40); checkOutput("target.valid", 32'(if_id_valid), 1); end
      25: begin
        checkOutput("flushAck.valid", 32'(if_id_valid), 0); checkOutput("flushAck.instr", if_id_instr, NOP);
        checkOutput("flushAck.addr", imem_addr, 32'h80);
      end
      27: begin
        checkOutput("wrap.pc", if_id_pc, 32'hFFFFFFFC); checkOutput("wrap.pc4", if_id_pc4, 32'h0);
        checkOutput("wrap.valid", 32'(if_id_valid), 1);
      end
      42: checkOutput("timeout.before", 32'(imem_err), 0);
      43: checkOutput("timeout.set", 32'(imem_err), 1);
      52: checkOutput("timeout.sticky", 32'(imem_err), 1);
      default: ;
    endcase
  endtask

  initial begin
    reset_n = 0; pc_in = 0; flush = 0; id_stall = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst.req", 32'(imem_req), 0);
    checkOutput("rst.instr", if_id_instr, NOP);
    checkOutput("rst.pc", if_id_pc, 32'h0);
    checkOutput("rst.pc4", if_id_pc4, 32'h0);
    checkOutput("rst.valid", 32'(if_id_valid), 0);
    checkOutput("rst.err", 32'(imem_err), 0);
    checkOutput("rst.stall", 32'(fetch_stall), 1);
    @(posedge clk);
    #1 reset_n = 1;
    @(negedge clk);
    checkOutput("idle.stall", 32'(fetch_stall), 1);
    checkOutput("idle.req", 32'(imem_req), 0);
    for (int c = 1; c <= 52; c++) begin
      applyStimulus(c);
      @(negedge clk);
      directedChecks(c);
    end
    // Reset in the middle of an outstanding request.
    @(posedge clk);
    #1 reset_n = 0;
    #2;
    checkOutput("midRst.req", 32'(imem_req), 0);
    checkOutput("midRst.valid", 32'(if_id_valid), 0);
    checkOutput("midRst.err", 32'(imem_err), 0);
    @(posedge clk);
    #1; pc_in = 32'h60; ackDelay = 0;
    @(posedge clk);
    #1 reset_n = 1;
    @(negedge clk);
    checkOutput("reIdle.req", 32'(imem_req), 0);
    @(negedge clk);
    checkOutput("reReq.req", 32'(imem_req), 1);
    checkOutput("reReq.addr", imem_addr, 32'h60);
    @(negedge clk);
    checkOutput("reLoad.pc", if_id_pc, 32'h60);
    checkOutput("reLoad.valid", 32'(if_id_valid), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
